// File: rtl/cnn_pkg.sv
// Shared CNN definitions: pooling window size, default data width and the
// pooling-arbiter state encoding.
package cnn_pkg;

  localparam int unsigned POOL_WIN       = 4;
  localparam int unsigned DEFAULT_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    WAIT,
    RESP
  } pool_arb_state_t;

endpackage

// File: rtl/avg_pool_arbiter_if.sv
// Requester-side bus of the pooling arbiter: window offer handshake plus the
// one-hot response pulse with its shared result word.
interface avg_pool_arbiter_if
  import cnn_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = DEFAULT_DATA_W
);

  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ*POOL_WIN*DATA_W-1:0] req_win;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [NUM_REQ-1:0]                 rsp_valid;
  logic [DATA_W-1:0]                  rsp_data;

  modport master (
    output req_valid, req_win,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_win,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/rr_grant.sv
// Combinational round-robin picker; with AVG_POOL_ARB_FIXED_PRIO_EN defined it
// becomes a lowest-index-wins priority encoder.
module rr_grant #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   index,
  output logic               any
);

  logic [IDX_W-1:0] pos;

`ifdef AVG_POOL_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;
`endif

  // First requesting index in search order wins.
  always_comb begin
    grant = '0;
    index = '0;
    any   = 1'b0;
    pos   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
`ifdef AVG_POOL_ARB_FIXED_PRIO_EN
      pos = IDX_W'(i);
`else
      pos = IDX_W'((32'(last_grant) + 32'd1 + i) % NUM_REQ);
`endif
      if (!any && req[pos]) begin
        any        = 1'b1;
        index      = pos;
        grant[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/avg_pool_arbiter.sv
// Shares one serial 2x2 average-pooling unit among NUM_REQ requesters.
// Round-robin by default; AVG_POOL_ARB_FIXED_PRIO_EN selects fixed priority.
module avg_pool_arbiter
  import cnn_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned DATA_W   = DEFAULT_DATA_W,
  parameter int unsigned UNIT_LAT = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  avg_pool_arbiter_if.slave        bus,
  output logic                     busy,
  output logic [DATA_W-1:0]        unit_ip,
  output logic                     unit_en,
  output logic                     unit_rst,
  input  logic [DATA_W-1:0]        unit_avg
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned K_W   = $clog2(POOL_WIN);
  localparam int unsigned LAT_W = $clog2(UNIT_LAT + 1);

  pool_arb_state_t   state_q, state_d;
  logic [K_W-1:0]    feed_k_q, feed_k_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]  last_grant_q, last_grant_d;
  logic [DATA_W-1:0] win_q [POOL_WIN];
  logic [DATA_W-1:0] win_d [POOL_WIN];
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic [NUM_REQ-1:0] req_ready;

  logic [NUM_REQ-1:0] pick;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  rr_grant #(.NUM_REQ(NUM_REQ)) u_rr_grant (
    .req        (bus.req_valid),
    .last_grant (last_grant_q),
    .grant      (pick),
    .index      (pick_idx),
    .any        (pick_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      feed_k_q     <= '0;
      lat_q        <= '0;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      for (int unsigned k = 0; k < POOL_WIN; k++) win_q[k] <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      feed_k_q     <= feed_k_d;
      lat_q        <= lat_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      win_q        <= win_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  // Accept -> clear unit -> feed 4 operands -> wait latency -> respond.
  always_comb begin
    state_d      = state_q;
    feed_k_d     = feed_k_q;
    lat_d        = lat_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    win_d        = win_q;
    rsp_valid_d  = '0;
    rsp_data_d   = rsp_data_q;
    req_ready    = '0;
    unit_rst     = 1'b0;
    unit_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          req_ready = pick;
          grant_d   = pick_idx;
          for (int unsigned k = 0; k < POOL_WIN; k++) begin
            win_d[k] = bus.req_win[(32'(pick_idx) * POOL_WIN + k) * DATA_W +: DATA_W];
          end
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        unit_rst = 1'b1;
        feed_k_d = '0;
        state_d  = FEED;
      end
      FEED: begin
        unit_en = 1'b1;
        if (feed_k_q == K_W'(POOL_WIN - 1)) begin
          lat_d   = '0;
          state_d = WAIT;
        end else begin
          feed_k_d = feed_k_q + K_W'(1);
        end
      end
      WAIT: begin
        // Result is captured on the last wait cycle so it is presented in RESP.
        if (lat_q == LAT_W'(UNIT_LAT - 1)) begin
          rsp_valid_d = NUM_REQ'(1) << grant_q;
          rsp_data_d  = unit_avg;
          state_d     = RESP;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      RESP: begin
        last_grant_d = grant_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign unit_ip       = win_q[feed_k_q];
  assign busy          = (state_q != IDLE);
  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_avg_pool_arbiter.sv
// Scoreboard bench for avg_pool_arbiter with a behavioural pool unit
// (accumulate, arithmetic shift right by 2, UNIT_LAT cycles after last feed).
module tb_avg_pool_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int LAT  = 3;
`ifdef AVG_POOL_ARB_FIXED_PRIO_EN
  localparam int OTHER = 1;
`else
  localparam int OTHER = 2;
`endif

  logic clk;
  logic rst;
  logic busy, unit_en, unit_rst;
  logic [DW-1:0] unit_ip, unit_avg;

  avg_pool_arbiter_if #(.NUM_REQ(NREQ), .DATA_W(DW)) bus ();

  avg_pool_arbiter #(.NUM_REQ(NREQ), .DATA_W(DW), .UNIT_LAT(LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .busy     (busy),
    .unit_ip  (unit_ip),
    .unit_en  (unit_en),
    .unit_rst (unit_rst),
    .unit_avg (unit_avg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural pool unit: result valid LAT cycles after the last enable.
  logic signed [DW+1:0] acc;
  logic [DW-1:0]        avg_s1;
  always @(posedge clk) begin
    if (rst || unit_rst) acc <= '0;
    else if (unit_en)    acc <= acc + $signed({{2{unit_ip[DW-1]}}, unit_ip});
    avg_s1   <= DW'(acc >>> 2);
    unit_avg <= avg_s1;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  int            exp_grant [$];
  int            exp_rsp_r [$];
  logic [DW-1:0] exp_rsp_d [$];
  int            rsp_cyc   [$];

  logic [DW-1:0] win_tab [NREQ][2][4];
  int            n_win [NREQ];
  int            cur   [NREQ];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Scoreboard monitor: compares grants and responses as the DUT presents them.
  int            mon_g, mon_r;
  logic [DW-1:0] mon_d;
  always @(negedge clk) begin
    if (bus.req_ready != '0) begin
      if (exp_grant.size() == 0) check("grant_unexpected", 64'(bus.req_ready), 64'd0);
      else begin
        mon_g = exp_grant.pop_front();
        check("grant_order", 64'(bus.req_ready), 64'(NREQ'(1) << mon_g));
      end
    end
    if (bus.rsp_valid != '0) begin
      rsp_cyc.push_back(cyc);
      if (exp_rsp_r.size() == 0) check("rsp_unexpected", 64'(bus.rsp_valid), 64'd0);
      else begin
        mon_r = exp_rsp_r.pop_front();
        mon_d = exp_rsp_d.pop_front();
        check("rsp_valid", 64'(bus.rsp_valid), 64'(NREQ'(1) << mon_r));
        check("rsp_data", 64'(bus.rsp_data), 64'(mon_d));
      end
    end
  end

  task automatic present(input int r);
    if (cur[r] < n_win[r]) begin
      for (int k = 0; k < 4; k++) bus.req_win[(r*4+k)*DW +: DW] = win_tab[r][cur[r]][k];
      bus.req_valid[r] = 1'b1;
    end else begin
      bus.req_valid[r] = 1'b0;
    end
  endtask

  // One clock: note acceptances, then advance each accepted requester.
  task automatic tick();
    logic [NREQ-1:0] seen;
    @(negedge clk);
    seen = bus.req_ready;
    @(posedge clk);
    #1;
    cyc++;
    for (int r = 0; r < NREQ; r++) begin
      if (seen[r]) begin
        cur[r]++;
        present(r);
      end
    end
  endtask

  task automatic set_win(input int r, input int s, input int a, input int b, input int c, input int d);
    win_tab[r][s][0] = DW'(a);
    win_tab[r][s][1] = DW'(b);
    win_tab[r][s][2] = DW'(c);
    win_tab[r][s][3] = DW'(d);
    n_win[r] = s + 1;
  endtask

  task automatic expect_rsp(input int r, input int v);
    exp_grant.push_back(r);
    exp_rsp_r.push_back(r);
    exp_rsp_d.push_back(DW'(v));
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    bus.req_win   = '0;
    for (int r = 0; r < NREQ; r++) begin
      n_win[r] = 0;
      cur[r]   = 0;
    end
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    cyc = 0;
    rsp_cyc.delete();
  endtask

  task automatic drain(input string name);
    int t;
    bit pend;
    t = 0;
    forever begin
      pend = 1'b0;
      for (int r = 0; r < NREQ; r++) if (cur[r] < n_win[r]) pend = 1'b1;
      if (!(pend || busy || exp_rsp_r.size() != 0) || t >= 200) break;
      tick();
      t++;
    end
    check(name, 64'(t < 200), 64'd1);
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_win   = '0;
    do_reset();

    // Reset state
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_unit_en", 64'(unit_en), 64'd0);
    check("rst_unit_rst", 64'(unit_rst), 64'd0);
    check("rst_unit_ip", 64'(unit_ip), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(bus.rsp_data), 64'd0);

    // T1: single requester, cycle-exact sequencing
    set_win(0, 0, 4, 8, 12, 16);
    expect_rsp(0, 10);
    present(0);
    #1;
    check("t1_ready_c0", 64'(bus.req_ready), 64'd1);
    check("t1_busy_c0", 64'(busy), 64'd0);
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("t1_unit_rst", 64'(unit_rst), 64'(i == 1));
      check("t1_unit_en", 64'(unit_en), 64'(i >= 2 && i <= 5));
      if (i >= 2 && i <= 5) check("t1_unit_ip", 64'(unit_ip), 64'(win_tab[0][0][i-2]));
      check("t1_rsp_valid", 64'(bus.rsp_valid), (i == 9) ? 64'd1 : 64'd0);
      check("t1_busy", 64'(busy), 64'(i <= 9));
      if (i == 9) check("t1_rsp_data", 64'(bus.rsp_data), 64'd10);
    end
    drain("t1_drain");

    // T2: all four together, served in order 10 cycles apart
    do_reset();
    set_win(0, 0, 1, 2, 3, 4);
    set_win(1, 0, 10, 20, 30, 40);
    set_win(2, 0, -8, -8, -8, -8);
    set_win(3, 0, 7, 7, 7, 9);
    expect_rsp(0, 2);
    expect_rsp(1, 25);
    expect_rsp(2, -8);
    expect_rsp(3, 7);
    for (int r = 0; r < NREQ; r++) present(r);
    drain("t2_drain");
    check("t2_rsp_count", 64'(rsp_cyc.size()), 64'd4);
    for (int i = 1; i < 4; i++) begin
      if (i < rsp_cyc.size()) check("t2_spacing", 64'(rsp_cyc[i] - rsp_cyc[i-1]), 64'd10);
    end

    // T3: two continuous requesters (alternate in RR, requester 0 always in fixed prio)
    do_reset();
    set_win(0, 0, 0, 0, 0, 4);
    set_win(0, 1, 0, 0, 0, 8);
    set_win(OTHER, 0, 0, 0, 0, 12);
    set_win(OTHER, 1, 0, 0, 0, 16);
`ifdef AVG_POOL_ARB_FIXED_PRIO_EN
    expect_rsp(0, 1);
    expect_rsp(0, 2);
    expect_rsp(1, 3);
    expect_rsp(1, 4);
`else
    expect_rsp(0, 1);
    expect_rsp(2, 3);
    expect_rsp(0, 2);
    expect_rsp(2, 4);
`endif
    present(0);
    present(OTHER);
    drain("t3_drain");

    // T4: negative window, floor rounding
    do_reset();
    set_win(0, 0, -4, -4, -4, -5);
    expect_rsp(0, -5);
    present(0);
    drain("t4_drain");

    // T5: reset during FEED k=2 drops the window; requester 1 wins afterwards
    do_reset();
    set_win(0, 0, 1, 2, 3, 4);
    exp_grant.push_back(0);
    present(0);
    repeat (4) tick();
    check("t5_feed_en", 64'(unit_en), 64'd1);
    check("t5_feed_ip", 64'(unit_ip), 64'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_post_rst_en", 64'(unit_en), 64'd0);
    check("t5_post_rst_busy", 64'(busy), 64'd0);
    check("t5_post_rst_rsp", 64'(bus.rsp_valid), 64'd0);
    set_win(1, 0, 2, 2, 2, 2);
    set_win(3, 0, 3, 3, 3, 3);
    expect_rsp(1, 2);
    expect_rsp(3, 3);
    present(1);
    present(3);
    drain("t5_drain");

    check("end_grant_queue", 64'(exp_grant.size()), 64'd0);
    check("end_rsp_queue", 64'(exp_rsp_r.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
